nbit_reg_arbiter: RTL and testbench
===================================

// Module: nbit_reg_arbiter
// PURPOSE
//  Round-robin write arbiter for one shared N-bit holding register: M requesters
//  compete for its write port, with at most one write per cycle.
//  Supports optional locked bursts, bounded by LOCK_MAX, so a requester can own the register for consecutive writes.
//  Sits between producer blocks and the shared register; the register lives inside this block.
// PARAMETERS
//  N        6   data width of the shared register
//  M        4   number of requesters (>=2)
//  LOCK_MAX 8   max consecutive cycles in LOCKED before forced release (>=1)
// PORTS
//  clk      in   1             clock, rising edge
//  rst      in   1             synchronous, active-high reset
//  req      in   M             per-requester write request, level
//  lock     in   M             per-requester lock request, sampled with req
//  wdata    in   M*N           requester i data at [i*N +: N]
//  gnt      out  M             one-hot grant: write of that requester occurs at this edge
//  q        out  N             shared register contents
//  q_owner  out  $clog2(M)     index of requester that performed the last write
//  q_valid  out  1             1 once any write has occurred since reset
//  locked   out  1             1 while FSM is in LOCKED
// BEHAVIOUR
//  Reset (rst=1 at edge): q=0, q_owner=0, q_valid=0, locked=0, ptr=0, hold_cnt=0, state=ARB.
//  gnt is combinational and is forced to 0 while rst=1.
//  States: ARB, LOCKED.
//  ARB:
//   - Winner = first i with req[i]=1, scanning ptr, ptr+1, ..., M-1, 0, ... (wrap modulo M).
//   - gnt[winner]=1 in the same cycle. At the edge: q<=wdata[winner], q_owner<=winner,
//     q_valid<=1, ptr<=(winner+1)%M (wraps M-1 -> 0).
//   - If lock[winner]=1: go to LOCKED with owner=winner and hold_cnt=1. Otherwise stay in ARB.
//   - No req: gnt=0, q, ptr and state all hold.
//  LOCKED:
//   - Only the owner is served. gnt[owner]=req[owner]. Other requests wait with gnt=0.
//   - A write occurs on each cycle with req[owner]=1, updating q and q_owner as in ARB.
//   - The cycle counter increments every LOCKED cycle, whether or not a write occurs.
//   - Exit to ARB at the edge when lock[owner]=0. The owner's write in that cycle, if req[owner]=1, still happens.
//   - Exit to ARB at the edge when hold_cnt==LOCK_MAX (forced release). The write in that cycle is still allowed.
//   - On exit: hold_cnt<=0 and ptr<=(owner+1)%M.
//  Timing:
//   - Latency: req[i] high in cycle k with i winning -> gnt[i] in cycle k -> new q visible in cycle k+1.
//   - Requests are level: a requester keeps req high until it sees gnt. A held req is served again
//     when its turn comes, so a single sole requester wins every cycle.
//   - Fairness: in ARB with all req high, grants rotate 0,1,...,M-1,0,...; any waiting requester
//     is served within M-1 ARB grants.
//   - locked = (state==LOCKED), registered.
//  Boundaries:
//   - gnt is always one-hot or zero. Simultaneous req on all lines -> exactly one gnt.
//   - lock without req is ignored.
//   - rst during LOCKED -> ARB next cycle, with all reset values applied, and no gnt in the rst cycle.
// TESTING
//  1. rst=1 for 2 cycles, req=4'b1111 -> gnt=0. After release: q=0, q_valid=0, locked=0.
//  2. req=4'b1111, lock=0, wdata[i]=i+1 -> gnt sequence 0001,0010,0100,1000,0001;
//     q follows 1,2,3,4,1 one cycle later.
//  3. Only req[2]=1, wdata[2]=6'h2A for 3 cycles -> gnt=0100 every cycle; q=6'h2A; q_owner=2.
//  4. Lock from requester 1:
//     - Start: req=4'b1111, lock[1]=1 at ptr=1 -> locked=1; only gnt=0010 while lock[1]=1.
//     - Normal release: drop lock[1] -> next grant goes to 2.
//  5. Forced release: lock[1] held, LOCK_MAX=8 -> exactly 8 LOCKED cycles with gnt=0010,
//     then locked=0 and next grant goes to 2 (or the next requesting index).
//  6. Reset during LOCKED -> rst=1 mid-burst gives gnt=0 that cycle; next cycle q=0, locked=0, ptr=0;
//     with req=4'b1111 the first grant goes to 0.

Source files
------------

// File: rtl/nbit_reg_arbiter.sv
// nbit_reg_arbiter
//   Round-robin write arbiter in front of one shared N-bit holding register.
//   M requesters compete for the write port and at most one write happens per
//   cycle. A winner that also raises lock can keep the register for a burst of
//   consecutive cycles. The burst is capped at LOCK_MAX cycles spent in LOCKED,
//   after which the arbiter releases it.
//
// Ports
//   clk      in   1           rising-edge clock
//   rst      in   1           synchronous, active-high reset
//   req      in   M           per-requester write request (level)
//   lock     in   M           per-requester lock request, sampled with req
//   wdata    in   M*N         requester i data at [i*N +: N]
//   gnt      out  M           one-hot grant (combinational); the write happens at this edge
//   q        out  N           shared register contents
//   q_owner  out  $clog2(M)   index of the requester that performed the last write
//   q_valid  out  1           set once any write has occurred since reset
//   locked   out  1           high while the FSM is in LOCKED
//
// FSM states
//   state     | meaning
//   ST_ARB    | round-robin scan from ptr; the winner writes and may start a lock
//   ST_LOCKED | only the owner is served; hold_cnt counts cycles spent in LOCKED

module nbit_reg_arbiter #(
  parameter int N        = 6,
  parameter int M        = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M-1:0]         req,
  input  logic [M-1:0]         lock,
  input  logic [M*N-1:0]       wdata,
  output logic [M-1:0]         gnt,
  output logic [N-1:0]         q,
  output logic [$clog2(M)-1:0] q_owner,
  output logic                 q_valid,
  output logic                 locked
);

  localparam int PW = $clog2(M);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [CW-1:0]   hold_cnt;

  logic [N-1:0]    wdata_arr [M];
  logic            found;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   wr_idx;
  logic            wr_en;
  logic            lock_exit;

  // Wraps M-1 back to 0, so M need not be a power of two.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    if (int'(i) == M - 1) return '0;
    return i + 1'b1;
  endfunction

  for (genvar i = 0; i < M; i++) begin : g_unpack
    assign wdata_arr[i] = wdata[i*N +: N];
  end

  // Round-robin scan: the first requester at or after ptr, wrapping modulo M.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < M; k++) begin
      idx = int'(ptr) + k;
      if (idx >= M) idx = idx - M;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  // The burst ends on the owner's own release or when the cycle cap is reached.
  // In both cases the owner's write in the final cycle still goes through.
  assign lock_exit = !lock[owner] || (hold_cnt == CW'(LOCK_MAX));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_ARB;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_ARB:    if (found && lock[winner]) state_next = ST_LOCKED;
      ST_LOCKED: if (lock_exit)             state_next = ST_ARB;
      default:                              state_next = ST_ARB;
    endcase
  end

  // Output logic. gnt is held low during reset even though req may be active.
  always_comb begin
    gnt    = '0;
    wr_idx = winner;
    if (!rst) begin
      case (state)
        ST_ARB: begin
          if (found) gnt[winner] = 1'b1;
        end
        ST_LOCKED: begin
          wr_idx     = owner;
          gnt[owner] = req[owner];
        end
        default: ;
      endcase
    end
  end

  assign wr_en  = |gnt;
  assign locked = (state == ST_LOCKED);

  // Shared register and arbitration bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      q_owner  <= '0;
      q_valid  <= 1'b0;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
    end else begin
      if (wr_en) begin
        q       <= wdata_arr[wr_idx];
        q_owner <= wr_idx;
        q_valid <= 1'b1;
      end
      case (state)
        ST_ARB: begin
          if (found) begin
            ptr <= next_idx(winner);
            if (lock[winner]) begin
              owner    <= winner;
              hold_cnt <= CW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (lock_exit) begin
            hold_cnt <= '0;
            ptr      <= next_idx(owner);
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(gnt));

endmodule

// File: tb/tb_nbit_reg_arbiter.sv
module tb_nbit_reg_arbiter;
  localparam int N = 6;
  localparam int M = 4;
  localparam int LOCK_MAX = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [M-1:0]   req;
  logic [M-1:0]   lock;
  logic [M*N-1:0] wdata;
  logic [M-1:0]   gnt;
  logic [N-1:0]   q;
  logic [1:0]     q_owner;
  logic           q_valid;
  logic           locked;

  int checks = 0;
  int errors = 0;

  nbit_reg_arbiter #(.N(N), .M(M), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .q(q), .q_owner(q_owner), .q_valid(q_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  // Every task starts and ends 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; lock = 4'b0000; wdata = {6'd4, 6'd3, 6'd2, 6'd1};
    #1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt cyc%0d: got %b want 0000", c, gnt); end
    end
    rst = 1'b0; req = 4'b0000;
    #1;
    checks++;
    if (q !== 6'd0) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++;
    if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid: got %b want 0", q_valid); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++;
    if (q_owner !== 2'd0) begin errors++; $display("FAIL reset_q_owner: got %0d want 0", q_owner); end
    tick();
  endtask

  task automatic test_rotation();
    logic [M-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] exp_q [5] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd1};
    req = 4'b1111; lock = 4'b0000; wdata = {6'd4, 6'd3, 6'd2, 6'd1};
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (gnt !== exp_g[k]) begin errors++; $display("FAIL rot_gnt step%0d: got %b want %b", k, gnt, exp_g[k]); end
      tick();
      checks++;
      if (q !== exp_q[k]) begin errors++; $display("FAIL rot_q step%0d: got %h want %h", k, q, exp_q[k]); end
      checks++;
      if (q_valid !== 1'b1) begin errors++; $display("FAIL rot_q_valid step%0d: got %b want 1", k, q_valid); end
    end
    req = 4'b0000;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b want 0000", gnt); end
    tick();
    checks++;
    if (q !== 6'd1) begin errors++; $display("FAIL idle_q_hold: got %h want 01", q); end
  endtask

  task automatic test_sole_requester();
    req = 4'b0100; lock = 4'b0000; wdata = {6'd4, 6'h2A, 6'd2, 6'd1};
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL sole_gnt cyc%0d: got %b want 0100", k, gnt); end
      tick();
      checks++;
      if (q !== 6'h2A) begin errors++; $display("FAIL sole_q cyc%0d: got %h want 2a", k, q); end
      checks++;
      if (q_owner !== 2'd2) begin errors++; $display("FAIL sole_owner cyc%0d: got %0d want 2", k, q_owner); end
    end
    req = 4'b0000;
  endtask

  // A single grant to requester 0 moves the pointer to 1.
  task automatic park_ptr_at_1();
    req = 4'b0001; lock = 4'b0000;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL park_gnt: got %b want 0001", gnt); end
    tick();
  endtask

  task automatic test_lock_release();
    wdata = {6'd4, 6'd3, 6'd2, 6'd1};
    park_ptr_at_1();
    req = 4'b1111; lock = 4'b0010;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_start_gnt: got %b want 0010", gnt); end
    tick();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_start_locked: got %b want 1", locked); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_hold_gnt cyc%0d: got %b want 0010", k, gnt); end
      tick();
    end
    lock = 4'b0000;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_last_gnt: got %b want 0010", gnt); end
    tick();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_release_locked: got %b want 0", locked); end
    #1;
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL lock_release_next: got %b want 0100", gnt); end
    tick();
    req = 4'b0000;
  endtask

  task automatic test_forced_release();
    int n_locked;
    int budget;
    wdata = {6'd4, 6'd3, 6'd2, 6'd1};
    park_ptr_at_1();
    req = 4'b1111; lock = 4'b0010;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL force_start_gnt: got %b want 0010", gnt); end
    tick();
    n_locked = 0;
    budget = 0;
    #1;
    while (locked === 1'b1 && budget < 20) begin
      if (gnt === 4'b0010) n_locked++;
      tick();
      #1;
      budget++;
    end
    checks++;
    if (budget >= 20) begin errors++; $display("FAIL force_timeout: still locked after %0d cycles, want release", budget); end
    checks++;
    if (n_locked !== LOCK_MAX) begin errors++; $display("FAIL force_cycles: got %0d want %0d", n_locked, LOCK_MAX); end
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL force_next_gnt: got %b want 0100", gnt); end
    tick();
    checks++;
    if (q !== 6'd3 || q_owner !== 2'd2) begin errors++; $display("FAIL force_next_q: got %h/%0d want 03/2", q, q_owner); end
    // lock with no req is ignored
    req = 4'b0000; lock = 4'b1111;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL lock_noreq_gnt: got %b want 0000", gnt); end
    tick();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_noreq_locked: got %b want 0", locked); end
    lock = 4'b0000;
  endtask

  // Pointer sits at 3 here, so requester 3 wins and locks.
  task automatic test_reset_in_lock();
    wdata = {6'd4, 6'd3, 6'd2, 6'd1};
    req = 4'b1111; lock = 4'b1000;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL rlock_start_gnt: got %b want 1000", gnt); end
    tick();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL rlock_locked: got %b want 1", locked); end
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL rlock_rst_gnt: got %b want 0000", gnt); end
    tick();
    rst = 1'b0; lock = 4'b0000;
    #1;
    checks++;
    if (locked !== 1'b0 || q !== 6'd0 || q_valid !== 1'b0) begin
      errors++; $display("FAIL rlock_post: got locked=%b q=%h valid=%b want 0/00/0", locked, q, q_valid);
    end
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL rlock_first_gnt: got %b want 0001", gnt); end
    tick();
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_sole_requester();
    test_lock_release();
    test_forced_release();
    test_reset_in_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
